// File: rtl/noc_node_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_node_tx_arbiter
// Purpose  : Packet-level round-robin arbiter that shares one NoC node sender
//            port among NUM_REQ local requesters. A requester wins with a
//            header flit while idle; the grant is then locked until its tail
//            handshake, so packets from different requesters never interleave.
//            Also counts forwarded packets and flags orphan body/tail flits.
// Ports    : noc_clk / noc_rst          clock, synchronous active-high reset
//            req_valid/ready/flit/
//            req_is_header/is_tail      per-requester flit channel
//            sender_valid/ready/flit/
//            sender_is_header/is_tail   shared channel toward the node
//            grant_id                   current or last granted requester
//            busy                       high while a packet is locked
//            pkt_count                  tail handshakes forwarded (wraps)
//            err_orphan                 sticky orphan body/tail flit flag
// Revision : 1.0 - initial release
// ============================================================================
module noc_node_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic                      sender_valid,
  input  logic                      sender_ready,
  output logic [DATA_W-1:0]         sender_flit,
  output logic                      sender_is_header,
  output logic                      sender_is_tail,
  output logic [REQ_W-1:0]          grant_id,
  output logic                      busy,
  output logic [15:0]               pkt_count,
  output logic                      err_orphan
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [REQ_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REQ_W-1:0]   grant_q, grant_d;
  logic [15:0]        pkt_count_q, pkt_count_d;
  logic               err_orphan_q, err_orphan_d;

  logic [NUM_REQ-1:0] cand;
  logic [REQ_W-1:0]   scan_idx;
  logic [REQ_W-1:0]   pick;
  logic               pick_found;
  logic               handshake;

  // Round-robin search: walk the requesters starting at rr_ptr and keep the
  // first one presenting a header.
  always_comb begin
    cand       = req_valid & req_is_header;
    scan_idx   = rr_ptr_q;
    pick       = rr_ptr_q;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = REQ_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && cand[scan_idx]) begin
        pick       = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    grant_d          = grant_q;
    pkt_count_d      = pkt_count_q;
    err_orphan_d     = err_orphan_q;
    req_ready        = '0;
    sender_valid     = 1'b0;
    sender_flit      = '0;
    sender_is_header = 1'b0;
    sender_is_tail   = 1'b0;
    handshake        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Nothing is accepted in idle: the winner's header is forwarded on
        // the following cycle, which costs one bubble per packet.
        if ((req_valid & ~req_is_header) != '0) begin
          err_orphan_d = 1'b1;
        end
        if (pick_found) begin
          grant_d = pick;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // Zero-latency forward of the locked requester's channel.
        sender_valid       = req_valid[grant_q];
        sender_flit        = req_flit[int'(grant_q)*DATA_W +: DATA_W];
        sender_is_header   = req_is_header[grant_q];
        sender_is_tail     = req_is_tail[grant_q];
        req_ready[grant_q] = sender_ready;
        handshake          = sender_valid & sender_ready;
        if (handshake && sender_is_tail) begin
          state_d     = ST_IDLE;
          rr_ptr_d    = REQ_W'((int'(grant_q) + 1) % NUM_REQ);
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      pkt_count_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      pkt_count_q  <= pkt_count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign grant_id   = grant_q;
  assign busy       = (state_q == ST_LOCKED);
  assign pkt_count  = pkt_count_q;
  assign err_orphan = err_orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_node_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_node_tx_arbiter
// Purpose  : Self-checking bench for noc_node_tx_arbiter: a vector table for
//            reset, single/multi-flit packets, round-robin order and orphan
//            flits; hand sequences for stalled lock, mid-packet reset and
//            counter wrap; randomized traffic against a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_node_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int REQ_W   = 2;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      noc_rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_is_header;
  logic [NUM_REQ-1:0]        req_is_tail;
  logic                      sender_valid;
  logic                      sender_ready;
  logic [DATA_W-1:0]         sender_flit;
  logic                      sender_is_header;
  logic                      sender_is_tail;
  logic [REQ_W-1:0]          grant_id;
  logic                      busy;
  logic [15:0]               pkt_count;
  logic                      err_orphan;

  logic [DATA_W-1:0]         fl [NUM_REQ];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_flit[i*DATA_W +: DATA_W] = fl[i];
  end

  noc_node_tx_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W), .DATA_W(DATA_W)) dut (
    .noc_clk          (clk),
    .noc_rst          (noc_rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_flit         (req_flit),
    .req_is_header    (req_is_header),
    .req_is_tail      (req_is_tail),
    .sender_valid     (sender_valid),
    .sender_ready     (sender_ready),
    .sender_flit      (sender_flit),
    .sender_is_header (sender_is_header),
    .sender_is_tail   (sender_is_tail),
    .grant_id         (grant_id),
    .busy             (busy),
    .pkt_count        (pkt_count),
    .err_orphan       (err_orphan)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rv, h, t;
    logic        sr;
    logic        sv;
    logic [3:0]  rr;
    logic        b;
    logic [1:0]  g;
    logic [15:0] c;
    logic [31:0] f;
    logic        oh, ot, e;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic rst, logic [3:0] rv, logic [3:0] h, logic [3:0] t,
                              logic sr, logic sv, logic [3:0] rr, logic b, logic [1:0] g,
                              logic [15:0] c, logic [31:0] f, logic oh, logic ot, logic e);
    vec_t v;
    v.rst = rst; v.rv = rv; v.h = h; v.t = t; v.sr = sr; v.sv = sv; v.rr = rr;
    v.b = b; v.g = g; v.c = c; v.f = f; v.oh = oh; v.ot = ot; v.e = e;
    return v;
  endfunction

  function automatic logic [63:0] pk(logic sv, logic [3:0] rr, logic b, logic [1:0] g,
                                     logic [15:0] c, logic [31:0] f, logic h, logic t, logic e);
    return {5'b0, sv, rr, b, g, c, f, h, t, e};
  endfunction

  function automatic logic [63:0] snap();
    return pk(sender_valid, req_ready, busy, grant_id, pkt_count, sender_flit,
              sender_is_header, sender_is_tail, err_orphan);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_is_header = '0; req_is_tail = '0; sender_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    noc_rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    noc_rst = 1'b0;
  endtask

  // Reference model state (packet-level view of the arbiter)
  int          m_owner, m_next, m_last;
  logic [15:0] m_cnt;
  logic        m_err;
  // Random requester drivers and per-requester scoreboard
  int          len [NUM_REQ];
  int          pos [NUM_REQ];
  logic        act [NUM_REQ];
  logic [27:0] tx  [NUM_REQ];
  logic [27:0] rx  [NUM_REQ];

  initial begin : main
    logic [31:0] got [$];
    logic [31:0] exp3 [5];
    logic [63:0] e;
    int          pos1;
    logic        done2;

    noc_rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < NUM_REQ; i++) fl[i] = 32'hC0DE_0000 | 32'(i);
    repeat (2) @(negedge clk);
    noc_rst = 1'b0;
    #1;
    check("reset_state", snap(), 64'd0);

    // ---------------- table-driven vectors ----------------
    //              rst  rv       h        t        sr | sv rr       b  g  cnt  flit          oh ot e
    tbl[0]  = mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 32'h0,         0, 0, 0);
    tbl[1]  = mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 4'b0001, 1, 0, 0, 32'hC0DE0000, 1, 0, 0);
    tbl[2]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 1, 4'b0001, 1, 0, 0, 32'hC0DE0000, 0, 0, 0);
    tbl[3]  = mk(0, 4'b0001, 4'b0000, 4'b0001, 1, 1, 4'b0001, 1, 0, 0, 32'hC0DE0000, 0, 1, 0);
    tbl[4]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 32'h0,         0, 0, 0);
    tbl[5]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 32'h0,         0, 0, 0);
    tbl[6]  = mk(0, 4'b1111, 4'b1111, 4'b1111, 1, 0, 4'b0000, 0, 0, 0, 32'h0,         0, 0, 0);
    tbl[7]  = mk(0, 4'b1111, 4'b1111, 4'b1111, 1, 1, 4'b0001, 1, 0, 0, 32'hC0DE0000, 1, 1, 0);
    tbl[8]  = mk(0, 4'b1110, 4'b1111, 4'b1111, 1, 0, 4'b0000, 0, 0, 1, 32'h0,         0, 0, 0);
    tbl[9]  = mk(0, 4'b1110, 4'b1111, 4'b1111, 1, 1, 4'b0010, 1, 1, 1, 32'hC0DE0001, 1, 1, 0);
    tbl[10] = mk(0, 4'b1100, 4'b1111, 4'b1111, 1, 0, 4'b0000, 0, 1, 2, 32'h0,         0, 0, 0);
    tbl[11] = mk(0, 4'b1100, 4'b1111, 4'b1111, 1, 1, 4'b0100, 1, 2, 2, 32'hC0DE0002, 1, 1, 0);
    tbl[12] = mk(0, 4'b1000, 4'b1111, 4'b1111, 1, 0, 4'b0000, 0, 2, 3, 32'h0,         0, 0, 0);
    tbl[13] = mk(0, 4'b1000, 4'b1111, 4'b1111, 1, 1, 4'b1000, 1, 3, 3, 32'hC0DE0003, 1, 1, 0);
    tbl[14] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 3, 4, 32'h0,         0, 0, 0);
    tbl[15] = mk(0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 3, 4, 32'h0,         0, 0, 0);
    tbl[16] = mk(0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 3, 4, 32'h0,         0, 0, 1);
    tbl[17] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 3, 4, 32'h0,         0, 0, 1);

    for (int r = 0; r < 18; r++) begin
      @(negedge clk);
      noc_rst       = tbl[r].rst;
      req_valid     = tbl[r].rv;
      req_is_header = tbl[r].h;
      req_is_tail   = tbl[r].t;
      sender_ready  = tbl[r].sr;
      #1;
      check($sformatf("vec%0d", r), snap(),
            pk(tbl[r].sv, tbl[r].rr, tbl[r].b, tbl[r].g, tbl[r].c, tbl[r].f,
               tbl[r].oh, tbl[r].ot, tbl[r].e));
    end
    @(negedge clk);
    noc_rst = 1'b0;
    idle_inputs();

    // ---------------- stalled lock: req1 4-flit vs req2 header ----------------
    do_reset();
    pos1 = 0; done2 = 1'b0;
    for (int c = 0; c < 40 && !(pos1 == 4 && done2); c++) begin
      @(negedge clk);
      req_valid        = {1'b0, !done2, pos1 < 4, 1'b0};
      fl[1]            = 32'h11 + 32'(pos1);
      req_is_header[1] = (pos1 == 0);
      req_is_tail[1]   = (pos1 == 3);
      fl[2]            = 32'h21;
      req_is_header[2] = 1'b1;
      req_is_tail[2]   = 1'b1;
      sender_ready     = (c % 2 == 0);
      #1;
      if (sender_valid && sender_ready) got.push_back(sender_flit);
      if (req_valid[1] && req_ready[1]) pos1++;
      if (req_valid[2] && req_ready[2]) done2 = 1'b1;
    end
    exp3[0] = 32'h11; exp3[1] = 32'h12; exp3[2] = 32'h13; exp3[3] = 32'h14; exp3[4] = 32'h21;
    check("lock_flit_count", 64'(got.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got.size()) check($sformatf("lock_flit%0d", k), 64'(got[k]), 64'(exp3[k]));
      else                check($sformatf("lock_flit%0d", k), 64'hDEAD, 64'(exp3[k]));
    end

    // ---------------- reset in the middle of a 4-flit packet ----------------
    // Here the round-robin pointer is 3 (req2 was the last winner).
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      req_valid[0]     = 1'b1;
      req_is_header[0] = (c < 2);
      fl[0]            = (c < 2) ? 32'hA0 : 32'hA1;
      noc_rst          = (c == 2);
    end
    @(negedge clk);
    noc_rst = 1'b0;
    idle_inputs();
    #1;
    check("rst_mid_pkt", snap(), 64'd0);
    @(negedge clk);
    req_valid = 4'b1100; req_is_header = 4'b1100; req_is_tail = 4'b1100;
    fl[2] = 32'hC2; fl[3] = 32'hC3;
    @(negedge clk);
    #1;
    check("rst_regrant", snap(), pk(1, 4'b0100, 1, 2, 0, 32'hC2, 1, 1, 0));
    @(negedge clk);
    idle_inputs();
    #1;
    check("rst_after_pkt", snap(), pk(0, 4'b0000, 0, 2, 1, 32'h0, 0, 0, 0));

    // ---------------- pkt_count wrap ----------------
    @(negedge clk);
    force dut.pkt_count_q = 16'hFFFF;
    #1;
    release dut.pkt_count_q;
    #1;
    check("wrap_preload", 64'(pkt_count), 64'hFFFF);
    @(negedge clk);
    req_valid = 4'b0001; req_is_header = 4'b0001; req_is_tail = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    check("wrap_zero", 64'(pkt_count), 64'h0);

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    m_owner = -1; m_next = 0; m_last = 0; m_cnt = '0; m_err = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      len[i] = $urandom_range(1, 4); pos[i] = 0; act[i] = 1'b0; tx[i] = '0; rx[i] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i]     = act[i];
        req_is_header[i] = (pos[i] == 0);
        req_is_tail[i]   = (pos[i] == len[i] - 1);
        fl[i]            = {4'(i), tx[i]};
      end
      sender_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (m_owner < 0)
        e = pk(0, 4'b0000, 0, 2'(m_last), m_cnt, 32'h0, 0, 0, m_err);
      else
        e = pk(req_valid[m_owner], 4'(sender_ready) << m_owner, 1, 2'(m_last), m_cnt,
               fl[m_owner], req_is_header[m_owner], req_is_tail[m_owner], m_err);
      check($sformatf("rand_cyc%0d", cyc), snap(), e);
      if (sender_valid && sender_ready && m_owner >= 0) begin
        check($sformatf("rand_order_req%0d", m_owner), 64'(sender_flit),
              64'({4'(m_owner), rx[m_owner]}));
        rx[m_owner]++;
      end
      // Model: a header wins in idle starting from the round-robin pointer;
      // the lock ends on the tail handshake.
      if (m_owner < 0) begin
        if ((req_valid & ~req_is_header) != '0) m_err = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (m_owner < 0 && req_valid[(m_next + k) % NUM_REQ]
              && req_is_header[(m_next + k) % NUM_REQ]) begin
            m_owner = (m_next + k) % NUM_REQ;
            m_last  = m_owner;
          end
        end
      end else if (req_valid[m_owner] && sender_ready && req_is_tail[m_owner]) begin
        m_cnt   = m_cnt + 16'd1;
        m_next  = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end
      // Requesters respond to the accept they observed.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          tx[i]++;
          pos[i]++;
          if (pos[i] == len[i]) begin
            pos[i] = 0;
            len[i] = $urandom_range(1, 4);
          end
          act[i] = ($urandom_range(0, 3) != 0);
        end else if (!act[i]) begin
          act[i] = ($urandom_range(0, 1) != 0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
